ucaspian_wb_host: RTL and testbench
===================================

Name: ucaspian_wb_host

Overview:
- Wishbone classic master that drives the ucaspian Wishbone slave register map from a pair of byte streams.
- Intended for a UART/USB byte link.
- Sits directly upstream of the slave: host bytes go in as command-register writes; response-register reads come back out as host bytes.
- Polls the slave status register so it never issues a transfer that would hit the slave's 127-cycle timeout.

Parameters:
- AdrWidth, 30: Wishbone word-address width.
- DatWidth, 32: Wishbone data width; only bits [7:0] carry payload.
- BaseAdr, 30'h0: word address of slave register 0.
- PollGap, 4: idle cycles between status polls when no work is pending. Range 0..255.
- TimeoutCycles, 200: watchdog limit, used only with the optional feature. Range 1..1023.
- ExpVersion, 4'h1: expected slave version field.

Ports:
- wb_clk_i  in  1  clock
- wb_rst_i  in  1  synchronous active-high reset
- wb_adr_o  out  AdrWidth  BaseAdr + register offset
- wb_dat_o  out  DatWidth  write data: {zeros, byte}
- wb_dat_i  in  DatWidth  read data
- wb_sel_o  out  DatWidth/8  always 'b0001
- wb_we_o  out  1  write enable
- wb_stb_o  out  1  strobe
- wb_cyc_o  out  1  cycle
- wb_ack_i  in  1  acknowledge
- s_data_i  in  8  host-to-core byte
- s_valid_i  in  1
- s_ready_o  out  1
- m_data_o  out  8  core-to-host byte
- m_valid_o  out  1
- m_ready_i  in  1
- ver_err_o  out  1  sticky: status version field != ExpVersion
- err_o  out  1  sticky watchdog error (optional feature)

Behaviour:
- Clocking and reset: one clock, wb_clk_i; reset wb_rst_i is synchronous and active-high.
- Reset values: all outputs 0; wb_sel_o = 'b0001. FSM in IDLE; gap counter 0; output register empty.
- Register offsets: STATUS = 0, RSP = 1, CMD = 2.
- STATUS fields: bit0 = cmd FIFO full; bit1 = rsp FIFO empty; [7:4] = version.
- All Wishbone outputs are registered.
  - cyc and stb rise together and are held, along with adr/we/dat, until the cycle in which wb_ack_i = 1.
  - Both drop on the next edge.
  - A new transfer never starts in the cycle after an ack; there is at least 1 dead cycle.
- IDLE:
  - Gap counter counts up to PollGap, then go to STAT.
  - Skip the gap (go to STAT immediately) if s_valid_i = 1 and the last status showed cmd not full.
- STAT: read at offset 0. On ack:
  - Latch wb_dat_i[7:0].
  - If [7:4] != ExpVersion, set ver_err_o and go to HALT.
  - Else if rsp not empty and m_valid_o = 0, go to RD.
  - Else if s_valid_i = 1 and cmd not full, go to WR.
  - Else go to IDLE with the gap counter cleared.
  - Reads have priority over writes so the core never stalls on a full response FIFO.
- WR: write at offset 2 with wb_dat_o[7:0] = s_data_i.
  - s_ready_o = wb_ack_i & (state == WR), combinational, so the byte is consumed exactly in the ack cycle.
  - s_data_i must remain stable while s_valid_i = 1.
  - Then go to IDLE.
- RD: read at offset 1.
  - On ack, capture wb_dat_i[7:0] into m_data_o and set m_valid_o the next cycle.
  - Then go to IDLE.
- Output register:
  - m_valid_o clears on m_valid_o & m_ready_i.
  - m_data_o is stable while m_valid_o = 1.
  - At most 1 byte is buffered.
- HALT: bus idle until reset; s_ready_o = 0.
- Minimum per-byte cost: 1 STAT + 1 data transfer with 1 dead cycle between them. With a zero-wait slave, one byte needs 4 cycles.
- Reset mid-transfer: cyc/stb drop at the next edge; the in-flight byte is lost; sticky errors clear.
- Simultaneous input byte and pending response: the response is read first; the write is retried after the next STAT.

Optional Feature:
- Macro: UCASPIAN_WB_HOST_WATCHDOG_EN
- Defined:
  - A 10-bit counter runs while cyc = 1; it clears on ack.
  - When the count reaches TimeoutCycles: drop cyc/stb, set err_o, go to HALT.
  - A write aborted by the watchdog does not assert s_ready_o.
- Undefined: err_o tied 0; no counter logic; the master waits for ack indefinitely.

Decomposition:
- Package ucaspian_wb_pkg holds:
  - register offsets RegStatus/RegRsp/RegCmd;
  - status bit indices StatCmdFull = 0, StatRspEmpty = 1;
  - version field slice;
  - WbVersion = 4'h1;
  - the FSM state enum (IDLE, STAT, WR, RD, HALT).
- No sub-module; the one-byte output register stays inline.

Test Plan:
- Reset, no stimulus, slave status 8'h12 (version 1, rsp empty) -> STAT reads at adr 0 every PollGap+2 cycles; no other transfers; m_valid_o = 0.
- s_data_i = 8'hA5 presented, status 8'h12 -> STAT then a write at adr BaseAdr+2 with wb_dat_o = 32'h000000A5 and wb_sel_o = 'b0001; s_ready_o pulses 1 cycle in the ack cycle.
- Status 8'h10 (rsp available) and slave rsp byte 8'h3C -> read at adr 1; m_data_o = 8'h3C, m_valid_o = 1, held until m_ready_i.
- Byte pending with status 8'h10 -> RD issued before WR. With m_ready_i = 0, the second available response is not read; the write proceeds.
- Status 8'h23 (version 2) -> ver_err_o = 1, bus idle thereafter; wb_rst_i pulse clears ver_err_o and resumes polling.
- Watchdog macro defined, TimeoutCycles = 8, slave never acks -> cyc drops after 8 cycles, err_o = 1, s_ready_o never asserted.

Source files
------------

// File: rtl/ucaspian_wb_pkg.sv
// Shared definitions for the ucaspian Wishbone host: slave register map,
// status-register layout and the host FSM state encoding.
package ucaspian_wb_pkg;

   localparam logic [1:0] RegStatus = 2'd0;
   localparam logic [1:0] RegRsp    = 2'd1;
   localparam logic [1:0] RegCmd    = 2'd2;

   localparam int StatCmdFull  = 0;
   localparam int StatRspEmpty = 1;
   localparam int VerMsb       = 7;
   localparam int VerLsb       = 4;

   localparam logic [3:0] WbVersion = 4'h1;

   typedef enum logic [2:0] {
      IDLE,
      STAT,
      WR,
      RD,
      HALT
   } state_t;

   function automatic logic [3:0] status_version(input logic [7:0] status);
      return status[VerMsb:VerLsb];
   endfunction

endpackage

// File: rtl/ucaspian_wb_host.sv
// Wishbone classic master bridging host byte streams onto the ucaspian slave.
// Optional bus watchdog enabled by defining UCASPIAN_WB_HOST_WATCHDOG_EN.
module ucaspian_wb_host
   import ucaspian_wb_pkg::*;
#(
   parameter int                  AdrWidth      = 30,
   parameter int                  DatWidth      = 32,
   parameter logic [AdrWidth-1:0] BaseAdr       = '0,
   parameter int                  PollGap       = 4,
   parameter int                  TimeoutCycles = 200,
   parameter logic [3:0]          ExpVersion    = WbVersion
) (
   input  logic                  wb_clk_i,
   input  logic                  wb_rst_i,
   output logic [AdrWidth-1:0]   wb_adr_o,
   output logic [DatWidth-1:0]   wb_dat_o,
   input  logic [DatWidth-1:0]   wb_dat_i,
   output logic [DatWidth/8-1:0] wb_sel_o,
   output logic                  wb_we_o,
   output logic                  wb_stb_o,
   output logic                  wb_cyc_o,
   input  logic                  wb_ack_i,
   input  logic [7:0]            s_data_i,
   input  logic                  s_valid_i,
   output logic                  s_ready_o,
   output logic [7:0]            m_data_o,
   output logic                  m_valid_o,
   input  logic                  m_ready_i,
   output logic                  ver_err_o,
   output logic                  err_o
);

   localparam logic [7:0] GapLimit = 8'(PollGap);

   state_t              state, state_n;
   logic                cyc_q, cyc_n;
   logic                we_q, we_n;
   logic [AdrWidth-1:0] adr_q, adr_n;
   logic [7:0]          dat_q, dat_n;
   logic [7:0]          gap_q, gap_n;
   logic                cmd_full_q, cmd_full_n;
   logic                ver_err_q, ver_err_n;
   logic                m_valid_q, m_valid_n;
   logic [7:0]          m_data_q, m_data_n;
   logic                xfer_done;
   logic [7:0]          stat_byte;

   logic [DatWidth-9:0] unused_dat;
   logic [9:0]          unused_timeout;
   assign unused_dat     = wb_dat_i[DatWidth-1:8];
   assign unused_timeout = 10'(TimeoutCycles);

`ifdef UCASPIAN_WB_HOST_WATCHDOG_EN
   localparam logic [9:0] WdLimit = 10'(TimeoutCycles - 1);
   logic [9:0] wd_cnt_q, wd_cnt_n;
   logic       err_q, err_n;
`endif

   always_comb begin
      state_n    = state;
      cyc_n      = cyc_q;
      we_n       = we_q;
      adr_n      = adr_q;
      dat_n      = dat_q;
      gap_n      = gap_q;
      cmd_full_n = cmd_full_q;
      ver_err_n  = ver_err_q;
      m_valid_n  = m_valid_q;
      m_data_n   = m_data_q;
      xfer_done  = cyc_q && wb_ack_i;
      stat_byte  = wb_dat_i[7:0];

      if (m_valid_q && m_ready_i)
         m_valid_n = 1'b0;

      case (state)
         IDLE: begin
            if (gap_q == GapLimit || (s_valid_i && !cmd_full_q)) begin
               state_n = STAT;
               cyc_n   = 1'b1;
               we_n    = 1'b0;
               adr_n   = BaseAdr + AdrWidth'(RegStatus);
               gap_n   = '0;
            end else begin
               gap_n = gap_q + 8'd1;
            end
         end
         // Response reads win over command writes so the slave never
         // backs up on a full response FIFO.
         STAT: begin
            if (xfer_done) begin
               cyc_n      = 1'b0;
               cmd_full_n = stat_byte[StatCmdFull];
               if (status_version(stat_byte) != ExpVersion) begin
                  ver_err_n = 1'b1;
                  state_n   = HALT;
               end else if (!stat_byte[StatRspEmpty] && !m_valid_q) begin
                  state_n = RD;
               end else if (s_valid_i && !stat_byte[StatCmdFull]) begin
                  state_n = WR;
               end else begin
                  state_n = IDLE;
                  gap_n   = '0;
               end
            end
         end
         WR: begin
            if (!cyc_q) begin
               cyc_n = 1'b1;
               we_n  = 1'b1;
               adr_n = BaseAdr + AdrWidth'(RegCmd);
               dat_n = s_data_i;
            end else if (wb_ack_i) begin
               cyc_n   = 1'b0;
               we_n    = 1'b0;
               dat_n   = '0;
               state_n = IDLE;
               gap_n   = '0;
            end
         end
         RD: begin
            if (!cyc_q) begin
               cyc_n = 1'b1;
               we_n  = 1'b0;
               adr_n = BaseAdr + AdrWidth'(RegRsp);
            end else if (wb_ack_i) begin
               cyc_n     = 1'b0;
               m_valid_n = 1'b1;
               m_data_n  = wb_dat_i[7:0];
               state_n   = IDLE;
               gap_n     = '0;
            end
         end
         HALT:    cyc_n = 1'b0;
         default: state_n = IDLE;
      endcase

`ifdef UCASPIAN_WB_HOST_WATCHDOG_EN
      wd_cnt_n = (cyc_q && !wb_ack_i) ? wd_cnt_q + 10'd1 : '0;
      err_n    = err_q;
      if (cyc_q && !wb_ack_i && wd_cnt_q == WdLimit) begin
         cyc_n    = 1'b0;
         we_n     = 1'b0;
         state_n  = HALT;
         err_n    = 1'b1;
         wd_cnt_n = '0;
      end
`endif
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state      <= IDLE;
         cyc_q      <= 1'b0;
         we_q       <= 1'b0;
         adr_q      <= '0;
         dat_q      <= '0;
         gap_q      <= '0;
         cmd_full_q <= 1'b0;
         ver_err_q  <= 1'b0;
         m_valid_q  <= 1'b0;
         m_data_q   <= '0;
      end else begin
         state      <= state_n;
         cyc_q      <= cyc_n;
         we_q       <= we_n;
         adr_q      <= adr_n;
         dat_q      <= dat_n;
         gap_q      <= gap_n;
         cmd_full_q <= cmd_full_n;
         ver_err_q  <= ver_err_n;
         m_valid_q  <= m_valid_n;
         m_data_q   <= m_data_n;
      end
   end

`ifdef UCASPIAN_WB_HOST_WATCHDOG_EN
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         wd_cnt_q <= '0;
         err_q    <= 1'b0;
      end else begin
         wd_cnt_q <= wd_cnt_n;
         err_q    <= err_n;
      end
   end
   assign err_o = err_q;
`else
   assign err_o = 1'b0;
`endif

   assign wb_adr_o  = adr_q;
   assign wb_dat_o  = {{(DatWidth-8){1'b0}}, dat_q};
   assign wb_sel_o  = {{(DatWidth/8-1){1'b0}}, 1'b1};
   assign wb_we_o   = we_q;
   assign wb_stb_o  = cyc_q;
   assign wb_cyc_o  = cyc_q;
   assign s_ready_o = wb_ack_i && cyc_q && (state == WR);
   assign m_data_o  = m_data_q;
   assign m_valid_o = m_valid_q;
   assign ver_err_o = ver_err_q;

endmodule

// File: tb/tb_ucaspian_wb_host.sv
// Scoreboard bench for ucaspian_wb_host against a zero-wait slave model;
// the stall scenario switches behaviour with UCASPIAN_WB_HOST_WATCHDOG_EN.
module tb_ucaspian_wb_host;
   import ucaspian_wb_pkg::*;

   localparam int          AdrWidth      = 30;
   localparam int          DatWidth      = 32;
   localparam logic [29:0] BaseAdr       = 30'h100;
   localparam int          PollGap       = 4;
   localparam int          TimeoutCycles = 8;

   typedef struct {
      logic [29:0] adr;
      logic        we;
      logic [31:0] dat;
   } xfer_t;

   logic        clock;
   logic        reset;
   logic [29:0] wb_adr_o;
   logic [31:0] wb_dat_o;
   logic [31:0] wb_dat_i;
   logic [3:0]  wb_sel_o;
   logic        wb_we_o, wb_stb_o, wb_cyc_o, wb_ack_i;
   logic [7:0]  s_data_i;
   logic        s_valid_i, s_ready_o;
   logic [7:0]  m_data_o;
   logic        m_valid_o, m_ready_i;
   logic        ver_err_o, err_o;

   logic        ack_en;
   logic [7:0]  slave_status;
   logic [7:0]  slave_rsp;

   xfer_t       exp_xfer[$];
   logic [7:0]  exp_byte[$];
   xfer_t       mon_x;
   int          checks = 0;
   int          passes = 0;
   int          cycle = 0;
   int          stat_count = 0;
   int          last_stat = 0;
   int          stat_interval = 0;
   int          last_wr = 0;
   int          wr_interval = 0;
   logic        prev_ack = 1'b0;

   ucaspian_wb_host #(
      .AdrWidth(AdrWidth), .DatWidth(DatWidth), .BaseAdr(BaseAdr),
      .PollGap(PollGap), .TimeoutCycles(TimeoutCycles), .ExpVersion(4'h1)
   ) dut (
      .wb_clk_i(clock), .wb_rst_i(reset),
      .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i),
      .wb_sel_o(wb_sel_o), .wb_we_o(wb_we_o), .wb_stb_o(wb_stb_o),
      .wb_cyc_o(wb_cyc_o), .wb_ack_i(wb_ack_i),
      .s_data_i(s_data_i), .s_valid_i(s_valid_i), .s_ready_o(s_ready_o),
      .m_data_o(m_data_o), .m_valid_o(m_valid_o), .m_ready_i(m_ready_i),
      .ver_err_o(ver_err_o), .err_o(err_o)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Zero-wait slave: combinational ack, register decode relative to BaseAdr.
   assign wb_ack_i = wb_cyc_o & wb_stb_o & ack_en;
   always_comb begin
      wb_dat_i = '0;
      if (wb_adr_o == BaseAdr + 30'(RegStatus))
         wb_dat_i = {24'h0, slave_status};
      else if (wb_adr_o == BaseAdr + 30'(RegRsp))
         wb_dat_i = {24'h0, slave_rsp};
   end

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual === expected)
         passes++;
      else
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
   endtask

   task automatic applyStimulus(input logic [7:0] status, input logic [7:0] rsp,
                                input logic [7:0] data, input logic valid,
                                input logic ready);
      @(posedge clock);
      #1;
      slave_status = status;
      slave_rsp    = rsp;
      s_data_i     = data;
      s_valid_i    = valid;
      m_ready_i    = ready;
   endtask

   task automatic waitSReady(input string name);
      for (int i = 0; i < 50; i++) begin
         @(negedge clock);
         if (s_ready_o) return;
      end
      checkOutput(name, s_ready_o, 1);
   endtask

   task automatic waitMValid(input string name);
      for (int i = 0; i < 50; i++) begin
         @(negedge clock);
         if (m_valid_o) return;
      end
      checkOutput(name, m_valid_o, 1);
   endtask

   task automatic waitVerErr(input string name);
      for (int i = 0; i < 50; i++) begin
         @(negedge clock);
         if (ver_err_o) return;
      end
      checkOutput(name, ver_err_o, 1);
   endtask

   task automatic waitCyc(input string name);
      for (int i = 0; i < 50; i++) begin
         @(negedge clock);
         if (wb_cyc_o) return;
      end
      checkOutput(name, wb_cyc_o, 1);
   endtask

   // Monitor: every non-status transfer and every host byte handed out is
   // matched against the queued expectations in order.
   always @(negedge clock) begin
      cycle++;
      if (reset) begin
         prev_ack = 1'b0;
      end else begin
         if (prev_ack)
            checkOutput("dead_cycle_after_ack", wb_cyc_o, 0);
         if (wb_cyc_o && wb_ack_i) begin
            if (wb_adr_o == BaseAdr && !wb_we_o) begin
               stat_count++;
               stat_interval = cycle - last_stat;
               last_stat     = cycle;
            end else begin
               checkOutput("xfer_sel", wb_sel_o, 4'b0001);
               if (exp_xfer.size() == 0) begin
                  checks++;
                  $display("[TB] FAIL unexpected_xfer: got adr 0x%0h we %0b, expected none",
                           wb_adr_o, wb_we_o);
               end else begin
                  mon_x = exp_xfer.pop_front();
                  checkOutput("xfer_adr", wb_adr_o, mon_x.adr);
                  checkOutput("xfer_we", wb_we_o, mon_x.we);
                  if (mon_x.we) begin
                     checkOutput("xfer_wdata", wb_dat_o, mon_x.dat);
                     checkOutput("s_ready_on_write_ack", s_ready_o, 1);
                     wr_interval = cycle - last_wr;
                     last_wr     = cycle;
                  end
               end
            end
         end
         if (s_ready_o && !(wb_cyc_o && wb_ack_i && wb_we_o))
            checkOutput("spurious_s_ready", s_ready_o, 0);
         if (m_valid_o && m_ready_i) begin
            if (exp_byte.size() == 0) begin
               checks++;
               $display("[TB] FAIL unexpected_m_byte: got 0x%0h, expected none", m_data_o);
            end else begin
               checkOutput("m_data", m_data_o, exp_byte.pop_front());
            end
         end
         prev_ack = wb_cyc_o && wb_ack_i;
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL global_timeout: got no finish, expected finish");
      $fatal(1, "[TB] simulation time limit");
   end

   initial begin
      int start_stats;
      int busy;
      int ready_seen;
      int high;
      reset        = 1'b1;
      ack_en       = 1'b1;
      slave_status = 8'h12;
      slave_rsp    = 8'h00;
      s_data_i     = 8'h00;
      s_valid_i    = 1'b0;
      m_ready_i    = 1'b0;
      repeat (3) @(negedge clock);

      checkOutput("reset_cyc", wb_cyc_o, 0);
      checkOutput("reset_stb", wb_stb_o, 0);
      checkOutput("reset_we", wb_we_o, 0);
      checkOutput("reset_adr", wb_adr_o, 0);
      checkOutput("reset_dat", wb_dat_o, 0);
      checkOutput("reset_sel", wb_sel_o, 4'b0001);
      checkOutput("reset_s_ready", s_ready_o, 0);
      checkOutput("reset_m_valid", m_valid_o, 0);
      checkOutput("reset_ver_err", ver_err_o, 0);
      checkOutput("reset_err", err_o, 0);
      @(posedge clock);
      #1 reset = 1'b0;

      // Idle polling only.
      start_stats = stat_count;
      repeat (40) @(negedge clock);
      checkOutput("idle_polls_seen", 32'((stat_count - start_stats) >= 5), 1);
      checkOutput("idle_poll_interval", stat_interval, PollGap + 2);
      checkOutput("idle_m_valid", m_valid_o, 0);

      // Two back-to-back command bytes.
      exp_xfer.push_back('{adr: BaseAdr + 30'd2, we: 1'b1, dat: 32'h000000A5});
      exp_xfer.push_back('{adr: BaseAdr + 30'd2, we: 1'b1, dat: 32'h0000005A});
      applyStimulus(8'h12, 8'h00, 8'hA5, 1'b1, 1'b0);
      waitSReady("write_a5_s_ready");
      @(posedge clock);
      #1 s_data_i = 8'h5A;
      waitSReady("write_5a_s_ready");
      @(posedge clock);
      #1 s_valid_i = 1'b0;
      checkOutput("write_byte_interval", wr_interval, 4);

      // Single response held until the host takes it.
      exp_xfer.push_back('{adr: BaseAdr + 30'd1, we: 1'b0, dat: 32'h0});
      exp_byte.push_back(8'h3C);
      applyStimulus(8'h10, 8'h3C, 8'h00, 1'b0, 1'b0);
      waitMValid("read_m_valid");
      repeat (8) @(negedge clock);
      checkOutput("read_m_valid_held", m_valid_o, 1);
      checkOutput("read_m_data_held", m_data_o, 8'h3C);
      applyStimulus(8'h12, 8'h3C, 8'h00, 1'b0, 1'b1);
      applyStimulus(8'h12, 8'h3C, 8'h00, 1'b0, 1'b0);
      @(negedge clock);
      checkOutput("read_m_valid_cleared", m_valid_o, 0);

      // Byte and response pending together: read first, then write.
      repeat (4) @(negedge clock);
      exp_xfer.push_back('{adr: BaseAdr + 30'd1, we: 1'b0, dat: 32'h0});
      exp_xfer.push_back('{adr: BaseAdr + 30'd2, we: 1'b1, dat: 32'h000000C3});
      exp_byte.push_back(8'h77);
      applyStimulus(8'h10, 8'h77, 8'hC3, 1'b1, 1'b0);
      waitSReady("prio_write_s_ready");
      @(posedge clock);
      #1 s_valid_i = 1'b0;
      repeat (12) @(negedge clock);
      checkOutput("prio_m_valid", m_valid_o, 1);
      checkOutput("prio_m_data", m_data_o, 8'h77);
      applyStimulus(8'h12, 8'h77, 8'h00, 1'b0, 1'b1);
      applyStimulus(8'h12, 8'h77, 8'h00, 1'b0, 1'b0);
      @(negedge clock);
      checkOutput("prio_m_valid_cleared", m_valid_o, 0);

      // Wrong slave version halts the master until reset.
      applyStimulus(8'h23, 8'h00, 8'h00, 1'b0, 1'b0);
      waitVerErr("ver_err_wait");
      checkOutput("ver_err_set", ver_err_o, 1);
      applyStimulus(8'h12, 8'h00, 8'h11, 1'b1, 1'b0);
      busy       = 0;
      ready_seen = 0;
      repeat (20) begin
         @(negedge clock);
         if (wb_cyc_o) busy++;
         if (s_ready_o) ready_seen++;
      end
      checkOutput("halt_bus_idle", busy, 0);
      checkOutput("halt_s_ready", ready_seen, 0);
      applyStimulus(8'h12, 8'h00, 8'h00, 1'b0, 1'b0);
      reset = 1'b1;
      repeat (2) @(posedge clock);
      #1 reset = 1'b0;
      @(negedge clock);
      checkOutput("ver_err_cleared", ver_err_o, 0);
      start_stats = stat_count;
      repeat (20) @(negedge clock);
      checkOutput("polling_resumed", 32'((stat_count - start_stats) >= 2), 1);

      // Slave stops acknowledging.
      @(posedge clock);
      #1 ack_en = 1'b0;
      waitCyc("stall_cyc_wait");
`ifdef UCASPIAN_WB_HOST_WATCHDOG_EN
      high = 0;
      while (wb_cyc_o && high < 50) begin
         high++;
         @(negedge clock);
      end
      checkOutput("wd_cyc_cycles", high, TimeoutCycles);
      checkOutput("wd_err", err_o, 1);
      busy = 0;
      repeat (10) begin
         @(negedge clock);
         if (wb_cyc_o) busy++;
      end
      checkOutput("wd_bus_idle", busy, 0);
      @(posedge clock);
      #1 reset = 1'b1;
      ack_en = 1'b1;
      repeat (2) @(posedge clock);
      #1 reset = 1'b0;
      @(negedge clock);
      checkOutput("wd_err_cleared", err_o, 0);
`else
      high = 0;
      repeat (20) begin
         @(negedge clock);
         if (wb_cyc_o) high++;
      end
      checkOutput("stall_cyc_held", high, 20);
      checkOutput("stall_err_low", err_o, 0);
      @(posedge clock);
      #1 ack_en = 1'b1;
      repeat (3) @(negedge clock);
      checkOutput("stall_released", wb_cyc_o, 0);
`endif

      repeat (10) @(negedge clock);
      checkOutput("exp_xfer_drained", exp_xfer.size(), 0);
      checkOutput("exp_byte_drained", exp_byte.size(), 0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
